booth_seq_multiplier: RTL and testbench

Parametrised, iterative signed/unsigned Booth multiplier: accepts a WIDTH×WIDTH operand pair over a valid/ready handshake, retires one Booth step per clock, and presents a registered 2·WIDTH-bit product until the consumer takes it. It replaces the unrolled fixed 8-bit combinational Booth array in the arithmetic datapath. The unrolled array spent one adder per step; this block reuses a single add/sub/shift unit across steps and adds a per-operation unsigned mode.

---
 rtl/mul_pkg.sv | 65 ++++++
 rtl/booth_step.sv | 71 +++++++
 rtl/booth_seq_multiplier.sv | 142 ++++++++++++++
 tb/tb_booth_seq_multiplier.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// ============================================================================
// Package     : mul_pkg
// Description : Shared types and width/latency helpers for the sequential
//               Booth multiplier (FSM states, Booth recode selections).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Partial-product selection produced by the Booth recoder
  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    ADD_M  = 3'd1,
    SUB_M  = 3'd2,
    ADD_2M = 3'd3,
    SUB_2M = 3'd4
  } recode_e;

  // Extended operand width: one guard bit for radix-2, two for radix-4
  // (radix-4 consumes bit pairs, so the extended width must stay even).
  function automatic int ext_width(input int width, input bit radix4);
    return radix4 ? (width + 2) : (width + 1);
  endfunction

  // Number of Booth steps for the radix-2 build
  function automatic int steps_r2(input int width);
    return width + 1;
  endfunction

  // Number of Booth steps for the radix-4 build
  function automatic int steps_r4(input int width);
    return (width / 2) + 1;
  endfunction

  // Radix-2 recoding of {Q[0], q-1}
  function automatic recode_e recode_r2(input logic [1:0] bits);
    case (bits)
      2'b01:   return ADD_M;
      2'b10:   return SUB_M;
      default: return ZERO;
    endcase
  endfunction

  // Modified-Booth radix-4 recoding of {Q[1], Q[0], q-1}
  function automatic recode_e recode_r4(input logic [2:0] bits);
    case (bits)
      3'b001, 3'b010: return ADD_M;
      3'b011:         return ADD_2M;
      3'b100:         return SUB_2M;
      3'b101, 3'b110: return SUB_M;
      default:        return ZERO;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_step.sv
// ============================================================================
// Module      : booth_step
// Description : One Booth iteration: recode the low multiplier bits, add or
//               subtract M / 2M into the accumulator, then arithmetic-shift
//               {A, Q, q-1} right by SH bits. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step
  import mul_pkg::*;
#(
  parameter int X  = 9,
  parameter int SH = 1
) (
  input  logic [X+1:0] acc_i,
  input  logic [X-1:0] q_i,
  input  logic         qm1_i,
  input  logic [X-1:0] m_i,
  output logic [X+1:0] acc_o,
  output logic [X-1:0] q_o,
  output logic         qm1_o
);

  localparam int AW = X + 2;
  localparam int FW = AW + X + 1;

  recode_e               sel;
  logic [AW-1:0]         m1;
  logic [AW-1:0]         m2;
  logic [AW-1:0]         addend;
  logic [AW-1:0]         sum;
  logic [FW-1:0]         full;
  logic signed [FW-1:0]  shifted;

  generate
    if (SH == 2) begin : g_radix4
      assign sel = recode_r4({q_i[1], q_i[0], qm1_i});
    end else begin : g_radix2
      assign sel = recode_r2({q_i[0], qm1_i});
    end
  endgenerate

  // Sign-extended M and 2M in accumulator width; the two guard bits keep
  // +-2M of the most negative operand representable.
  assign m1 = {{2{m_i[X-1]}}, m_i};
  assign m2 = {m_i[X-1], m_i, 1'b0};

  // Select the partial product to accumulate this step
  always_comb begin
    addend = '0;
    case (sel)
      ADD_M:   addend = m1;
      SUB_M:   addend = ~m1 + 1'b1;
      ADD_2M:  addend = m2;
      SUB_2M:  addend = ~m2 + 1'b1;
      default: addend = '0;
    endcase
  end

  assign sum     = acc_i + addend;
  assign full    = {sum, q_i, qm1_i};
  assign shifted = $signed(full) >>> SH;

  assign acc_o = shifted[FW-1 -: AW];
  assign q_o   = shifted[X:1];
  assign qm1_o = shifted[0];

endmodule

`default_nettype wire

// File: rtl/booth_seq_multiplier.sv
// ============================================================================
// Module      : booth_seq_multiplier
// Description : Iterative signed/unsigned Booth multiplier with valid/ready
//               handshakes on both sides. One Booth step per clock through a
//               shared add/sub/shift unit; product held until consumed.
//               Define BOOTH_RADIX4_EN for the radix-4 (2 bits per cycle)
//               build; default build is radix-2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

`ifdef BOOTH_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
  localparam int STEPS  = steps_r4(WIDTH);
  localparam int SH     = 2;
`else
  localparam bit RADIX4 = 1'b0;
  localparam int STEPS  = steps_r2(WIDTH);
  localparam int SH     = 1;
`endif

  localparam int X  = ext_width(WIDTH, RADIX4);
  localparam int AW = X + 2;
  localparam int CW = $clog2(STEPS + 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [X-1:0]         q_q, q_d;
  logic                 qm1_q, qm1_d;
  logic [X-1:0]         m_q, m_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [AW-1:0]        step_acc;
  logic [X-1:0]         step_q;
  logic                 step_qm1;
  logic                 ext_m;
  logic                 ext_q;

  booth_step #(
    .X  (X),
    .SH (SH)
  ) u_step (
    .acc_i (acc_q),
    .q_i   (q_q),
    .qm1_i (qm1_q),
    .m_i   (m_q),
    .acc_o (step_acc),
    .q_o   (step_q),
    .qm1_o (step_qm1)
  );

  // Extension bit: sign bit in signed mode, zero in unsigned mode
  assign ext_m = signed_mode & multiplicand[WIDTH-1];
  assign ext_q = signed_mode & multiplier[WIDTH-1];

  // State, datapath and counter registers; reset discards any operation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      qm1_q     <= qm1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in RUN, hold result in DONE
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    q_d       = q_q;
    qm1_d     = qm1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          acc_d   = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(STEPS);
          m_d     = {{(X-WIDTH){ext_m}}, multiplicand};
          q_d     = {{(X-WIDTH){ext_q}}, multiplier};
        end
      end
      RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        qm1_d = step_qm1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = DONE;
          product_d = {step_acc[2*WIDTH-X-1:0], step_q};
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule

`default_nettype wire

// File: tb/tb_booth_seq_multiplier.sv
// ============================================================================
// Module      : tb_booth_seq_multiplier
// Description : Directed self-checking bench for booth_seq_multiplier
//               (WIDTH=8), covering reset, signed/unsigned products,
//               backpressure, mid-operation reset and back-to-back traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_booth_seq_multiplier;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 9;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        signed_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int n_vec;
  int n_err;

  booth_seq_multiplier #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .signed_mode  (signed_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] m, input logic [7:0] q, input logic s);
    int a;
    int b;
    logic [31:0] t;
    a = s ? int'($signed(m)) : int'(m);
    b = s ? int'($signed(q)) : int'(q);
    t = a * b;
    return t[15:0];
  endfunction

  // Offer an operand pair, wait for the accept edge, then drop in_valid
  task automatic start_op(input logic [7:0] m, input logic [7:0] q, input logic s);
    int guard;
    @(negedge clk);
    multiplicand = m;
    multiplier   = q;
    signed_mode  = s;
    in_valid     = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (!in_ready) begin
      n_err++;
      $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid     = 1'b0;
    multiplicand = 8'hA5;
    multiplier   = 8'h5A;
    n_vec++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL run_flags: in_ready=%b busy=%b required 0/1", in_ready, busy);
    end
  endtask

  // Count cycles from the accept edge until out_valid is observed
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 60);
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL valid_timeout: out_valid=%b required 1 after %0d cycles", out_valid, lat);
    end
  endtask

  // Complete the output handshake and check the return to IDLE
  task automatic finish_op;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_return: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic check_op(input string name, input logic [7:0] m, input logic [7:0] q,
                          input logic s, input logic [15:0] exp_p);
    int lat;
    start_op(m, q, s);
    wait_valid(lat);
    n_vec++;
    if (product !== exp_p) begin
      n_err++;
      $display("FAIL %s product: got %h required %h", name, product, exp_p);
    end
    n_vec++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, LAT);
    end
    finish_op();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b product=%h required 1/0/0/0000",
               in_ready, out_valid, busy, product);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_signed;
    check_op("s_m7x3",     8'hF9, 8'h03, 1'b1, 16'hFFEB);
    check_op("s_m128sq",   8'h80, 8'h80, 1'b1, 16'h4000);
    check_op("s_m128x127", 8'h80, 8'h7F, 1'b1, 16'hC080);
    check_op("s_m1sq",     8'hFF, 8'hFF, 1'b1, 16'h0001);
    check_op("s_127sq",    8'h7F, 8'h7F, 1'b1, 16'h3F01);
  endtask

  task automatic test_unsigned;
    check_op("u_255sq",    8'hFF, 8'hFF, 1'b0, 16'hFE01);
    check_op("u_128x2",    8'h80, 8'h02, 1'b0, 16'h0100);
    check_op("u_255x1",    8'hFF, 8'h01, 1'b0, 16'h00FF);
    check_op("u_0x128",    8'h00, 8'h80, 1'b0, 16'h0000);
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(8'hF9, 8'h03, 1'b1);
    wait_valid(lat);
    multiplicand = 8'hFF;
    multiplier   = 8'hFF;
    signed_mode  = 1'b0;
    in_valid     = 1'b1;
    for (int k = 0; k < 20; k++) begin
      n_vec++;
      if (product !== 16'hFFEB || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: product=%h out_valid=%b in_ready=%b required FFEB/1/0",
                 k, product, out_valid, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL bp_second_accept: busy=%b required 1", busy);
    end
    wait_valid(lat);
    n_vec++;
    if (product !== 16'hFE01 || lat != LAT) begin
      n_err++;
      $display("FAIL bp_second: product=%h lat=%0d required FE01/%0d", product, lat, LAT);
    end
    finish_op();
  endtask

  task automatic test_reset_mid;
    start_op(8'h12, 8'h34, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || product !== 16'h0000 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: out_valid=%b product=%h in_ready=%b busy=%b required 0/0000/1/0",
               out_valid, product, in_ready, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset", 8'h12, 8'h34, 1'b1, 16'h03A8);
  endtask

  task automatic test_back_to_back;
    int lat;
    int stall;
    int n_in;
    int n_out;
    logic [7:0]  m;
    logic [7:0]  q;
    logic        s;
    logic [15:0] exp_p;
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 2000; i++) begin
      m     = 8'($urandom);
      q     = 8'($urandom);
      s     = 1'($urandom);
      exp_p = ref_mul(m, q, s);
      stall = $urandom_range(0, 3);
      start_op(m, q, s);
      n_in++;
      if (stall == 0) out_ready = 1'b1;
      wait_valid(lat);
      for (int k = 0; k < stall; k++) @(negedge clk);
      n_vec++;
      if (product !== exp_p || lat != LAT) begin
        n_err++;
        $display("FAIL rand[%0d] %h*%h s=%b: product=%h lat=%0d required %h/%0d",
                 i, m, q, s, product, lat, exp_p, LAT);
      end
      finish_op();
      n_out++;
    end
    n_vec++;
    if (n_in != n_out) begin
      n_err++;
      $display("FAIL rand_count: outputs=%0d required %0d", n_out, n_in);
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = 8'h00;
    multiplier   = 8'h00;
    signed_mode  = 1'b0;
    test_reset();
    test_signed();
    test_unsigned();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
